// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared FSM states, register map, status bit positions and BCD range helper
package bin2bcd_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic ADDR_VALUE = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;
    localparam int BIT_BUSY = 0;
    localparam int BIT_OVERFLOW = 1;
    localparam int BIT_LOST = 2;
    function automatic int max_val(input int digits);
        int p = 1;
        for (int i = 0; i < digits; i++) p *= 10;
        return p - 1;
    endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_digit_adjust (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_display_feeder.sv
// bin2bcd_display_feeder: Avalon-MM slave converting a written binary value to packed BCD by sequential double-dabble
module bin2bcd_display_feeder
    import bin2bcd_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int BIN_W = 20,
    parameter int MAX_VAL = max_val(DIGITS)
) (
    input  logic                  clk_50Mhz,
    input  logic                  reset_n,
    input  logic                  address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  busy
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    logic [1:0] state;
    logic [BCD_W+BIN_W-1:0] sr, sr_next;
    logic [BCD_W-1:0] adj;
    logic [CW-1:0] cnt;
    logic overflow, lost, ovf_pend;
    logic wr_value, can_start, loss, status_read;
    logic [31:0] status;
    logic unused;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (.d(sr[BIN_W+4*g +: 4]), .q(adj[4*g +: 4]));
    end

    assign sr_next = {adj[BCD_W-2:0], sr[BIN_W-1:0], 1'b0};
    assign wr_value = write && address == ADDR_VALUE;
    assign can_start = (state == IDLE || state == DONE) && !ovf_pend;
    assign loss = wr_value && !can_start;
    assign status_read = read && address == ADDR_STATUS;
    assign busy = state == SHIFT;
    assign bcd_valid = state == DONE;
    assign unused = ^{writedata[31:BIN_W], adj[BCD_W-1]};

    always_comb begin
        status = '0;
        status[BIT_BUSY] = busy;
        status[BIT_OVERFLOW] = overflow;
        status[BIT_LOST] = lost;
    end

    always_ff @(posedge clk_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
            bcd_out <= '0;
            readdata <= '0;
            overflow <= 1'b0;
            lost <= 1'b0;
            ovf_pend <= 1'b0;
        end else begin
            if (read) readdata <= address == ADDR_STATUS ? status : 32'(bcd_out);
            lost <= loss || (lost && !status_read);
            // out-of-range values report one cycle after the write, through a pending cycle in IDLE
            if (ovf_pend) begin
                ovf_pend <= 1'b0;
                bcd_out <= ALL_NINES;
                state <= DONE;
            end else if (state == SHIFT) begin
                sr <= sr_next;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    cnt <= '0;
                    bcd_out <= sr_next[BCD_W+BIN_W-1 -: BCD_W];
                    overflow <= 1'b0;
                    state <= DONE;
                end
            end else if (wr_value) begin
                if (writedata[BIN_W-1:0] > MAX_BIN) begin
                    overflow <= 1'b1;
                    ovf_pend <= 1'b1;
                    state <= IDLE;
                end else begin
                    sr <= {{BCD_W{1'b0}}, writedata[BIN_W-1:0]};
                    cnt <= '0;
                    state <= SHIFT;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_display_feeder.sv
// tb_bin2bcd_display_feeder: scoreboard bench with a decimal-arithmetic reference model
module tb_bin2bcd_display_feeder;
    typedef struct {
        logic [23:0] d;
        int lat;
        int cyc;
    } exp_t;

    logic clk_50Mhz = 1'b0;
    logic reset_n = 1'b0;
    logic address = 1'b0;
    logic write = 1'b0;
    logic [31:0] writedata = '0;
    logic read = 1'b0;
    logic [31:0] readdata;
    logic [23:0] bcd_out;
    logic bcd_valid;
    logic busy;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    bin2bcd_display_feeder dut (
        .clk_50Mhz(clk_50Mhz), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata), .bcd_out(bcd_out),
        .bcd_valid(bcd_valid), .busy(busy)
    );

    always #10 clk_50Mhz = ~clk_50Mhz;
    always @(posedge clk_50Mhz) cyc <= cyc + 1;

    function automatic logic [23:0] bcd_of(input int v);
        logic [23:0] r = '0;
        if (v > 999999) return 24'h999999;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(negedge clk_50Mhz) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (reset_n && bcd_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(bcd_out), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("bcd_out", 32'(bcd_out), 32'(e.d));
                chk("latency", cyc - e.cyc, e.lat);
            end
        end
    end

    task automatic do_write(input logic [31:0] wd, input bit accept);
        int v;
        @(negedge clk_50Mhz);
        address = 1'b0;
        writedata = wd;
        write = 1'b1;
        @(negedge clk_50Mhz);
        write = 1'b0;
        v = int'(wd[19:0]);
        if (accept) sb.push_back('{bcd_of(v), v > 999999 ? 1 : 20, cyc});
    endtask

    task automatic do_read(input logic a, output logic [31:0] d);
        @(negedge clk_50Mhz);
        address = a;
        read = 1'b1;
        @(negedge clk_50Mhz);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk_50Mhz);
            n++;
        end
        chk("done_timeout", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk_50Mhz);
    endtask

    task automatic run_one(input logic [31:0] wd, input int exp_busy);
        int b0;
        logic [31:0] d;
        b0 = busy_cnt;
        do_write(wd, 1'b1);
        wait_done();
        chk("busy_cycles", busy_cnt - b0, exp_busy);
        do_read(1'b0, d);
        chk("read_value", d, 32'(bcd_of(int'(wd[19:0]))));
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] wd;
        int n;
        #1;
        chk("rst_readdata", readdata, 0);
        chk("rst_bcd_out", 32'(bcd_out), 0);
        chk("rst_bcd_valid", 32'(bcd_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        repeat (3) @(negedge clk_50Mhz);
        reset_n = 1'b1;

        run_one(32'd123456, 20);
        do_read(1'b1, d);
        chk("status_123456", d, 32'h0);

        run_one(32'd0, 20);
        run_one(32'd999999, 20);

        run_one(32'd1000000, 0);
        do_read(1'b1, d);
        chk("status_overflow", d, 32'h2);

        do_write(32'd500, 1'b1);
        repeat (4) @(negedge clk_50Mhz);
        do_write(32'd777, 1'b0);
        wait_done();
        do_read(1'b1, d);
        chk("status_lost", d, 32'h4);
        do_read(1'b1, d);
        chk("status_lost_cleared", d, 32'h0);

        do_write(32'd7, 1'b1);
        n = 0;
        while (!bcd_valid && n < 60) begin
            @(negedge clk_50Mhz);
            n++;
        end
        chk("b2b_done_seen", 32'(bcd_valid), 1);
        address = 1'b0;
        writedata = 32'd31;
        write = 1'b1;
        @(negedge clk_50Mhz);
        write = 1'b0;
        sb.push_back('{bcd_of(31), 20, cyc});
        wait_done();
        do_read(1'b0, d);
        chk("b2b_value", d, 32'h31);
        do_read(1'b1, d);
        chk("b2b_status", d, 32'h0);

        for (int i = 0; i < 25; i++) begin
            wd = $urandom;
            if (i % 5 == 0) wd[19:0] = 20'(999990 + $urandom_range(0, 20));
            run_one(wd, int'(wd[19:0]) > 999999 ? 0 : 20);
            do_read(1'b1, d);
            chk("rand_status", d, int'(wd[19:0]) > 999999 ? 32'h2 : 32'h0);
        end

        do_write(32'd654321, 1'b0);
        repeat (9) @(negedge clk_50Mhz);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_bcd_out", 32'(bcd_out), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(bcd_valid), 0);
        chk("abort_readdata", readdata, 0);
        repeat (2) @(negedge clk_50Mhz);
        reset_n = 1'b1;
        repeat (25) @(negedge clk_50Mhz);
        chk("abort_no_result", 32'(bcd_out), 0);
        run_one(32'd42, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
